// File: rtl/keypad_pkg.sv
// Shared types for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner_n.sv
// ROWS x COLS keypad scanner: column ring drive, debounced press/release, one-shot key index.
module keypad_scanner_n #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 12000,
    parameter int unsigned DEBOUNCE = 20,
    localparam int unsigned CODE_W  = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_err
);

    import keypad_pkg::*;

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE);

    kp_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [COL_W-1:0]  col_idx;
    logic [COL_W-1:0]  col_next;
    logic [CNT_W-1:0]  cnt;
    logic [ROWS-1:0]   row_n_sync;
    logic [ROWS-1:0]   rows;
    logic [ROWS-1:0]   cap_rows;
    logic [ROW_W-1:0]  cap_row;
    logic [ROW_W-1:0]  row_enc;
    logic              rows_multi;

    sync2 #(
        .WIDTH       (ROWS),
        .RESET_VALUE ({ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_n_sync)
    );

    assign rows       = ~row_n_sync;
    assign rows_multi = |(rows & (rows - 1'b1));
    assign tick       = (tick_cnt == TICK_LAST);
    assign col_next   = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

    always_comb begin
        col_n = ~(COLS'(1) << col_idx);
    end

    always_comb begin
        row_enc = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (rows[r]) row_enc = ROW_W'(r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            state     <= SCAN;
            col_idx   <= '0;
            cnt       <= '0;
            cap_rows  <= '0;
            cap_row   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_err <= 1'b0;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (rows == '0) begin
                            col_idx <= col_next;
                        end else if (rows_multi) begin
                            multi_err <= 1'b1;
                            col_idx   <= col_next;
                        end else begin
                            cap_rows <= rows;
                            cap_row  <= row_enc;
                            cnt      <= CNT_W'(1);
                            state    <= keypad_pkg::DEBOUNCE;
                        end
                    end
                    // The package state name is qualified: the DEBOUNCE parameter shadows it here.
                    keypad_pkg::DEBOUNCE: begin
                        if (rows == cap_rows) begin
                            if (cnt >= CNT_DONE) begin
                                state     <= PRESSED;
                                key_code  <= CODE_W'(32'(cap_row) * COLS + 32'(col_idx));
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_next;
                        end
                    end
                    PRESSED: begin
                        if (rows == '0) begin
                            cnt   <= CNT_W'(1);
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (rows == '0) begin
                            if (cnt >= CNT_DONE) begin
                                key_held <= 1'b0;
                                state    <= SCAN;
                                col_idx  <= col_next;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
